// File: rtl/cache_line_fill_pkg.sv
// Shared cache definitions: fill FSM states, address field widths and
// slice positions used by the cache controller and the line-fill engine.
package cache_line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } fill_state_t;

  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 10;
  localparam int OFFSET_W = 2;
  localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;

  localparam int OFFSET_LSB = 0;
  localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
  localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[TAG_LSB +: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_LSB +: INDEX_W];
  endfunction

endpackage

// File: rtl/cache_line_fill.sv
// Cache miss refill engine: fetches the four words of a line from main
// memory in order, assembles them and writes the line in a single cycle.
module cache_line_fill
  import cache_line_fill_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_W         = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fill_req,
  input  logic [ADDR_W-1:0]                fill_addr,
  output logic                             fill_busy,
  output logic                             fill_done,
  output logic                             mem_rd,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic                             mem_ack,
  input  logic [WORD_W-1:0]                mem_data,
  output logic                             line_we,
  output logic [INDEX_W-1:0]               line_index,
  output logic [TAG_W-1:0]                 line_tag,
  output logic [WORDS_PER_LINE*WORD_W-1:0] line_data,
  output logic [15:0]                      fill_count
);

  fill_state_t         state, next_state;
  logic [OFFSET_W-1:0] beat;
  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  index_q;
  logic [WORD_W-1:0]   buffer [WORDS_PER_LINE];
  logic [15:0]         count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Request latching, beat capture and the completed-fill counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat    <= '0;
      tag_q   <= '0;
      index_q <= '0;
      count_q <= '0;
      for (int k = 0; k < WORDS_PER_LINE; k++) buffer[k] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fill_req) begin
            tag_q   <= get_tag(fill_addr);
            index_q <= get_index(fill_addr);
            beat    <= '0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            buffer[beat] <= mem_data;
            beat         <= beat + 1'b1;
          end
        end
        WRITE:   count_q <= count_q + 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    mem_rd     = 1'b0;
    line_we    = 1'b0;
    fill_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fill_req) next_state = FETCH;
      end
      FETCH: begin
        mem_rd = 1'b1;
        if (mem_ack && beat == OFFSET_W'(WORDS_PER_LINE - 1)) next_state = WRITE;
      end
      WRITE: begin
        line_we    = 1'b1;
        fill_done  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    line_data = '0;
    for (int k = 0; k < WORDS_PER_LINE; k++) line_data[k*WORD_W +: WORD_W] = buffer[k];
  end

  // The offset of the miss is irrelevant: beats always walk the line from word 0.
  assign mem_addr   = (state == FETCH) ? {tag_q, index_q, beat} : '0;
  assign fill_busy  = (state != IDLE);
  assign line_index = index_q;
  assign line_tag   = tag_q;
  assign fill_count = count_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed self-checking bench for cache_line_fill: normal, stalled, busy,
// reset-abort, back-to-back and counter-wrap fills.
module tb_cache_line_fill;

  logic         clk = 1'b0;
  logic         rst;
  logic         fill_req;
  logic [14:0]  fill_addr;
  logic         fill_busy;
  logic         fill_done;
  logic         mem_rd;
  logic [14:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_data;
  logic         line_we;
  logic [9:0]   line_index;
  logic [2:0]   line_tag;
  logic [127:0] line_data;
  logic [15:0]  fill_count;

  int checks  = 0;
  int errors  = 0;
  int weCount = 0;

  cache_line_fill dut (
    .clk        (clk),
    .rst        (rst),
    .fill_req   (fill_req),
    .fill_addr  (fill_addr),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .line_we    (line_we),
    .line_index (line_index),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (line_we) weCount++;

  task automatic step;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic req, input logic [14:0] addr,
                               input logic ack, input logic [31:0] data);
    fill_req  = req;
    fill_addr = addr;
    mem_ack   = ack;
    mem_data  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [15:0] expCount);
    checkOutput({tag, "_busy"}, fill_busy, 1'b0);
    checkOutput({tag, "_rd"}, mem_rd, 1'b0);
    checkOutput({tag, "_we"}, line_we, 1'b0);
    checkOutput({tag, "_done"}, fill_done, 1'b0);
    checkOutput({tag, "_maddr"}, mem_addr, 15'h0);
    checkOutput({tag, "_count"}, fill_count, expCount);
  endtask

  // One complete fill; data word b is base*(b+1). When poke is set a second
  // request to 0x7FFF is held throughout FETCH and must be ignored.
  task automatic runFill(input logic [14:0] addr, input int stall, input logic [31:0] base,
                         input logic poke, input logic [15:0] expCount);
    int weBefore;
    logic [127:0] expLine;
    logic [14:0] otherAddr;
    weBefore  = weCount;
    expLine   = '0;
    otherAddr = poke ? 15'h7FFF : addr;
    applyStimulus(1'b1, addr, 1'b0, 32'h0);
    step;
    applyStimulus(poke, otherAddr, 1'b0, 32'h0);
    checkOutput("fetch_busy", fill_busy, 1'b1);
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < stall; s++) begin
        checkOutput("stall_addr", mem_addr, {addr[14:2], b[1:0]});
        checkOutput("stall_we", line_we, 1'b0);
        applyStimulus(poke, otherAddr, 1'b0, 32'hDEAD_BEEF);
        step;
      end
      checkOutput("beat_addr", mem_addr, {addr[14:2], b[1:0]});
      checkOutput("beat_rd", mem_rd, 1'b1);
      checkOutput("beat_we", line_we, 1'b0);
      applyStimulus(poke, otherAddr, 1'b1, base * (b + 1));
      expLine[32*b +: 32] = base * (b + 1);
      step;
    end
    applyStimulus(1'b0, addr, 1'b0, 32'h0);
    checkOutput("write_we", line_we, 1'b1);
    checkOutput("write_done", fill_done, 1'b1);
    checkOutput("write_rd", mem_rd, 1'b0);
    checkOutput("write_busy", fill_busy, 1'b1);
    checkOutput("write_index", line_index, addr[11:2]);
    checkOutput("write_tag", line_tag, addr[14:12]);
    checkOutput("write_line", line_data, expLine);
    step;
    checkIdle("after_fill", expCount);
    checkOutput("after_line", line_data, expLine);
    checkOutput("we_pulses", weCount, weBefore + 1);
    step;
    checkOutput("no_queue_busy", fill_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 15'h0, 1'b0, 32'h0);
    step;
    step;
    checkIdle("reset", 16'h0);
    checkOutput("reset_line", line_data, 128'h0);
    checkOutput("reset_tag", line_tag, 3'h0);
    checkOutput("reset_index", line_index, 10'h0);
    rst = 1'b1;
    applyStimulus(1'b0, 15'h0, 1'b1, 32'h1234_5678);
    step;
    checkIdle("ack_in_idle", 16'h0);

    $display("[TB] basic fill");
    runFill(15'h1A07, 0, 32'h11, 1'b0, 16'd1);
    checkOutput("basic_line", line_data, 128'h00000044_00000033_00000022_00000011);
    checkOutput("basic_index", line_index, 10'h281);

    $display("[TB] stalled fill");
    runFill(15'h1A07, 3, 32'h11, 1'b0, 16'd2);

    $display("[TB] busy rejection");
    runFill(15'h0123, 1, 32'h0101_0101, 1'b1, 16'd3);

    $display("[TB] reset mid-fill");
    begin
      int weBefore;
      weBefore = weCount;
      applyStimulus(1'b1, 15'h1234, 1'b0, 32'h0);
      step;
      applyStimulus(1'b0, 15'h1234, 1'b1, 32'hAAAA_0001);
      step;
      step;
      step;
      checkOutput("pre_reset_busy", fill_busy, 1'b1);
      rst = 1'b0;
      #1;
      checkIdle("async_reset", 16'h0);
      checkOutput("async_line", line_data, 128'h0);
      checkOutput("async_tag", line_tag, 3'h0);
      step;
      step;
      rst = 1'b1;
      applyStimulus(1'b0, 15'h0, 1'b0, 32'h0);
      step;
      checkIdle("post_reset", 16'h0);
      checkOutput("abort_no_we", weCount, weBefore);
    end
    runFill(15'h4000, 0, 32'h0101_0101, 1'b0, 16'd1);

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 15'h2468, 1'b1, 32'h5);
    step;
    step;
    step;
    step;
    step;
    checkOutput("b2b_we1", line_we, 1'b1);
    step;
    checkOutput("b2b_gap_busy", fill_busy, 1'b0);
    checkOutput("b2b_gap_count", fill_count, 16'd2);
    step;
    checkOutput("b2b_refetch_busy", fill_busy, 1'b1);
    checkOutput("b2b_refetch_addr", mem_addr, 15'h2468);
    step;
    step;
    step;
    step;
    checkOutput("b2b_we2", line_we, 1'b1);
    checkOutput("b2b_line", line_data, {4{32'h5}});
    applyStimulus(1'b0, 15'h0, 1'b0, 32'h0);
    step;
    checkIdle("b2b_end", 16'd3);

    $display("[TB] counter wrap");
    force dut.count_q = 16'hFFFF;
    step;
    release dut.count_q;
    checkOutput("wrap_preset", fill_count, 16'hFFFF);
    runFill(15'h0ABC, 1, 32'h0F0F, 1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
